// File: rtl/demux_hs.sv
// demux_hs: routes one valid/ready input stream to one of NCH output channels.
// The block has a single registered holding stage. Output data is one shared
// bus, and out_valid marks which channels still have to take the held word.
// An out-of-range select is accepted and dropped, and it raises a one-cycle
// err_sel pulse.
// Optional feature, enabled by defining DEMUX_HS_BROADCAST_EN: in_sel == NCH
// sends the word to every channel. Each channel then completes on its own.
module demux_hs #(
    parameter int DW    = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic             err_sel
);

    // Select code equal to the channel count. It is the first illegal index,
    // or the broadcast code when broadcast is enabled.
    localparam logic [SEL_W-1:0] NCH_CODE = SEL_W'(NCH);

    logic [DW-1:0]  hold_data;
    logic [DW-1:0]  hold_data_next;
    logic [NCH-1:0] hold_mask;
    logic [NCH-1:0] hold_mask_next;
    logic [NCH-1:0] remaining;
    logic           err_sel_next;
    logic           accept;
    logic           in_range;

`ifdef DEMUX_HS_BROADCAST_EN
    logic is_bcast;
    assign is_bcast = (in_sel == NCH_CODE);
`endif

    // Channels that stay pending after this edge. If none remain, the holding
    // stage is free, so the block can take a new word in the same cycle that
    // the old word drains.
    assign remaining = hold_mask & ~out_ready;
    assign in_ready  = (remaining == '0);
    assign accept    = in_valid & in_ready;
    assign in_range  = (in_sel < NCH_CODE);

    assign out_data  = hold_data;
    assign out_valid = hold_mask;

    // Next-state logic. Accepting a new word overrides the clear of the
    // completing word.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        hold_data_next = hold_data;
        hold_mask_next = remaining;
        err_sel_next   = 1'b0;
        if (accept) begin
            if (in_range) begin
                hold_data_next = in_data;
                hold_mask_next = NCH'(1) << in_sel;
            end
`ifdef DEMUX_HS_BROADCAST_EN
            else if (is_bcast) begin
                hold_data_next = in_data;
                hold_mask_next = '1;
            end
`endif
            else begin
                // Dropped word: nothing becomes pending and the old payload
                // stays on the bus.
                hold_mask_next = '0;
                err_sel_next   = 1'b1;
            end
        end
    end

    // Holding-stage registers. An asynchronous reset discards any pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: hold_data is an ordinary register, not a memory, so it is
            // reset along with the mask. This keeps out_data at zero after reset.
            hold_data <= '0;
            hold_mask <= '0;
            err_sel   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples values from before the edge.
            hold_data <= hold_data_next;
            hold_mask <= hold_mask_next;
            err_sel   <= err_sel_next;
        end
    end

endmodule

// File: tb/tb_demux_hs.sv
// tb_demux_hs: table-driven and randomized self-checking bench for demux_hs.
// It follows whether DEMUX_HS_BROADCAST_EN is defined.
module tb_demux_hs;

    localparam int DW    = 8;
    localparam int NCH   = 4;
    localparam int SEL_W = 3;

`ifdef DEMUX_HS_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    out_data;
    logic [NCH-1:0]   out_valid;
    logic [NCH-1:0]   out_ready;
    logic             err_sel;

    int n_checks = 0;
    int n_fail   = 0;

    demux_hs #(.DW(DW), .NCH(NCH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. Each channel is treated as an independent pending flag.
    // The producer may hand over a new word once every pending channel has its
    // consumer ready.
    bit [NCH-1:0]  m_pend;
    logic [DW-1:0] m_data;
    bit            m_err;

    function automatic bit m_can_accept(input logic [NCH-1:0] rdy);
        for (int k = 0; k < NCH; k++)
            if (m_pend[k] && !rdy[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_pend = '0;
        m_data = '0;
        m_err  = 1'b0;
    endtask

    task automatic m_edge(input logic v, input logic [SEL_W-1:0] s,
                          input logic [DW-1:0] d, input logic [NCH-1:0] rdy);
        bit acc;
        int idx;
        acc = v && m_can_accept(rdy);
        for (int k = 0; k < NCH; k++)
            if (m_pend[k] && rdy[k]) m_pend[k] = 1'b0;
        m_err = 1'b0;
        if (acc) begin
            idx = int'(s);
            if (idx < NCH) begin
                m_pend      = '0;
                m_pend[idx] = 1'b1;
                m_data      = d;
            end else if (BCAST && idx == NCH) begin
                m_pend = '1;
                m_data = d;
            end else begin
                m_pend = '0;
                m_err  = 1'b1;
            end
        end
    endtask

    // One clock cycle. The task starts 1 time unit after a rising edge and
    // ends 1 time unit after the next one. It compares in_ready before the
    // edge and the registered outputs after it against the model.
    task automatic cycle(input logic v, input logic [SEL_W-1:0] s,
                         input logic [DW-1:0] d, input logic [NCH-1:0] rdy,
                         output logic pre_rdy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
        #1;
        pre_rdy = in_ready;
        check("model in_ready", 32'(in_ready), 32'(m_can_accept(rdy)));
        @(posedge clk);
        m_edge(v, s, d, rdy);
        #1;
        check("model out_valid", 32'(out_valid), 32'(m_pend));
        check("model out_data", 32'(out_data), 32'(m_data));
        check("model err_sel", 32'(err_sel), 32'(m_err));
    endtask

    typedef struct {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic [DW-1:0]    data;
        logic [NCH-1:0]   ready;
        logic             exp_rdy;
        logic [NCH-1:0]   exp_ov;
        logic [DW-1:0]    exp_od;
        logic             exp_err;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    initial begin
        logic r;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = '0;
        in_data   = 8'hFF;
        out_ready = '0;
        m_reset();

        // Hold reset with in_valid high. Nothing may be captured.
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out_data", 32'(out_data), 32'h0);
        check("reset err_sel", 32'(err_sel), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("reset release in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Directed vectors. in_ready is sampled before the edge and the
        // outputs after it.
        vecs = '{
            '{1'b1, 3'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 8'hA0, 1'b0},
            '{1'b1, 3'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 8'hA1, 1'b0},
            '{1'b1, 3'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100, 8'hA2, 1'b0},
            '{1'b1, 3'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000, 8'hA3, 1'b0},
            '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'hA3, 1'b0},
            '{1'b1, 3'd2, 8'h5C, 4'b0000, 1'b1, 4'b0100, 8'h5C, 1'b0},
            '{1'b1, 3'd0, 8'h77, 4'b0000, 1'b0, 4'b0100, 8'h5C, 1'b0},
            '{1'b1, 3'd0, 8'h77, 4'b0000, 1'b0, 4'b0100, 8'h5C, 1'b0},
            '{1'b1, 3'd0, 8'h77, 4'b0000, 1'b0, 4'b0100, 8'h5C, 1'b0},
            '{1'b1, 3'd0, 8'h77, 4'b0100, 1'b1, 4'b0001, 8'h77, 1'b0},
            '{1'b0, 3'd0, 8'h00, 4'b0001, 1'b1, 4'b0000, 8'h77, 1'b0},
            '{1'b1, 3'd5, 8'h99, 4'b0000, 1'b1, 4'b0000, 8'h77, 1'b1},
            '{1'b0, 3'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 8'h77, 1'b0},
            '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h77, 1'b0},
            '{1'b1, 3'd1, 8'h11, 4'b0000, 1'b1, 4'b0010, 8'h11, 1'b0},
            '{1'b1, 3'd3, 8'h22, 4'b1101, 1'b0, 4'b0010, 8'h11, 1'b0},
            '{1'b0, 3'd0, 8'h00, 4'b0010, 1'b1, 4'b0000, 8'h11, 1'b0}
        };
        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ready, r);
            check($sformatf("vec%0d in_ready", i), 32'(r), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
            check($sformatf("vec%0d err_sel", i), 32'(err_sel), 32'(vecs[i].exp_err));
        end

        // Select code equal to NCH: broadcast or out-of-range.
`ifdef DEMUX_HS_BROADCAST_EN
        cycle(1'b1, 3'd4, 8'h3E, 4'b0000, r);
        check("bcast out_valid", 32'(out_valid), 32'hF);
        check("bcast out_data", 32'(out_data), 32'h3E);
        check("bcast err_sel", 32'(err_sel), 32'h0);
        cycle(1'b1, 3'd0, 8'h44, 4'b0001, r);
        check("bcast step1 in_ready", 32'(r), 32'h0);
        check("bcast step1 mask", 32'(out_valid), 32'hE);
        cycle(1'b1, 3'd0, 8'h44, 4'b0110, r);
        check("bcast step2 in_ready", 32'(r), 32'h0);
        check("bcast step2 mask", 32'(out_valid), 32'h8);
        cycle(1'b0, 3'd0, 8'h44, 4'b1000, r);
        check("bcast step3 in_ready", 32'(r), 32'h1);
        check("bcast step3 mask", 32'(out_valid), 32'h0);
`else
        cycle(1'b1, 3'd4, 8'h3E, 4'b0000, r);
        check("sel4 out_valid", 32'(out_valid), 32'h0);
        check("sel4 out_data", 32'(out_data), 32'h11);
        check("sel4 err_sel", 32'(err_sel), 32'h1);
        cycle(1'b0, 3'd0, 8'h00, 4'b0000, r);
        check("sel4 err_sel drop", 32'(err_sel), 32'h0);
`endif

        // Reset in the middle of a transfer, applied between edges.
        cycle(1'b1, 3'd1, 8'h4D, 4'b0000, r);
        check("midreset pending", 32'(out_valid), 32'h2);
        in_valid  = 1'b0;
        out_ready = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset async out_valid", 32'(out_valid), 32'h0);
        check("midreset async out_data", 32'(out_data), 32'h0);
        #2;
        rst_n = 1'b1;
        m_reset();
        #1;
        check("midreset release in_ready", 32'(in_ready), 32'h1);
        cycle(1'b0, 3'd0, 8'h00, 4'b1111, r);
        check("midreset no replay", 32'(out_valid), 32'h0);

        // Randomized traffic against the model. The ready bits are biased so
        // that stalls and multi-cycle holds happen often.
        for (int i = 0; i < 400; i++) begin
            logic [NCH-1:0] rdy;
            rdy = NCH'($urandom) & NCH'($urandom | $urandom);
            cycle(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)),
                  DW'($urandom), rdy, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_hs.md
Name: demux_hs

Overview:
- Parametrised successor to the team's 1:2 combinational demux: routes one input stream to one of NCH output channels.
- Uses a valid/ready handshake on the input and on every output channel, with one registered holding stage.
- Sits between a single producer and NCH consumers.
- Out-of-range selects are flagged, not silently routed.
- Output data is a single shared bus, qualified per channel by out_valid.

Parameters:
- DW, 8, data width in bits.
- NCH, 4, number of output channels; legal range 2..16.
- SEL_W, 3, select width; must satisfy 2**SEL_W > NCH so that code NCH is representable.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DW  input payload.
- in_sel  input  SEL_W  destination channel index.
- in_valid  input  1  input transfer request.
- in_ready  output  1  block can accept this cycle.
- out_data  output  DW  shared output payload for all channels.
- out_valid  output  NCH  bit k: channel k has pending data.
- out_ready  input  NCH  bit k: channel k consumer accepts.
- err_sel  output  1  one-cycle pulse: an out-of-range select was accepted and dropped.

Behaviour:
- State: hold_data[DW], hold_mask[NCH] (pending channels), err_sel register.
  - out_data = hold_data.
  - out_valid = hold_mask.
- Reset (rst_n low, asynchronous): hold_data=0, hold_mask=0, err_sel=0.
  - Hence out_valid=0 and out_data=0.
  - in_ready=1 whenever rst_n is high and hold_mask=0.
- Channel transfer: channel k completes on a clock edge where out_valid[k]=1 and out_ready[k]=1.
  - Next state: hold_mask_next = hold_mask & ~out_ready.
- in_ready = ((hold_mask & ~out_ready) == 0), purely combinational.
  - Asserted when the block is empty, or when every pending channel completes this cycle.
  - This allows back-to-back throughput of one word per cycle.
- Input acceptance: on an edge with in_valid=1 and in_ready=1:
  - hold_data <= in_data.
  - hold_mask <= onehot(in_sel) if in_sel < NCH.
  - Acceptance overrides the clear of the completing word in the same cycle.
- Latency: a word accepted at edge n is presented with out_valid at edge n+1.
  - No combinational path from in_data to out_data.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_valid[k] and out_data must not change.
  - out_ready may toggle arbitrarily without affecting this rule.
- Out-of-range select (in_sel >= NCH, subject to Optional Feature):
  - The word is accepted, hold_mask <= 0 and hold_data is unchanged.
  - err_sel <= 1 for exactly one cycle.
  - err_sel <= 0 on every edge without such an acceptance.
- in_valid=0: no state change except clearing of completed channels.
- out_ready bits for channels with out_valid=0 are ignored.
- Reset asserted mid-transfer: the pending word is discarded; no output is re-presented after reset.

Optional Feature:
- Macro DEMUX_HS_BROADCAST_EN.
- Defined: in_sel == NCH is a broadcast.
  - hold_mask <= all ones, so every channel receives the same word.
  - Each channel completes independently as its out_ready arrives.
  - in_ready stays low until the last pending channel completes, using the same in_ready equation.
  - err_sel fires only for in_sel > NCH.
- Undefined: in_sel == NCH is out-of-range (dropped, err_sel pulse). No broadcast logic is synthesised.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0000, out_data=0x00, err_sel=0. Release reset → in_ready=1.
- Routing: all out_ready=1; send sel=0..3 with data 0xA0..0xA3 on consecutive cycles.
  - Expected: out_valid 0001, 0010, 0100, 1000 on successive cycles, each one cycle after its acceptance, with matching data.
  - in_ready stays 1 throughout.
- Backpressure: send sel=2, data=0x5C with out_ready=0000 for 3 cycles while in_valid stays high with data 0x77.
  - Expected: out_valid=0100 and out_data=0x5C held; in_ready=0.
  - When out_ready[2]=1, 0x77 is accepted on that same edge.
- Out-of-range: NCH=4, send sel=5 → accepted, out_valid stays 0000, err_sel=1 for exactly one cycle.
  - Macro undefined: sel=4 also produces err_sel.
- Broadcast (macro defined): send sel=4, data=0x3E.
  - out_valid=1111; raise out_ready as 0001, then 0110, then 1000.
  - Expected: mask becomes 1110, then 1000, then 0000; in_ready=1 only in the cycle ready[3] completes.
- Mid-transfer reset: with out_valid=0010 and out_ready=0, pulse rst_n low between edges.
  - Expected: out_valid drops immediately (asynchronous) and in_ready=1 after release.
